// File: rtl/jtframe_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM requesters.
// Each slot keeps a one-word cache (tag + data); hits answer combinationally, misses queue for the SDRAM.
module jtframe_rom_arb #(
  parameter int SLOTS = 4,
  parameter int AW    = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS*32-1:0] slot_dout,
  output logic [SLOTS-1:0]    slot_ok,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic [31:0]         data_read,
  input  logic                data_rdy
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  state_t            state_q;
  logic [IW-1:0]     gnt_q;
  logic [IW-1:0]     rr_q;
  logic              req_q;
  logic [AW-1:0]     addr_q;
  logic [SLOTS-1:0]  valid_q;
  logic [AW-1:0]     tag_q  [SLOTS];
  logic [31:0]       data_q [SLOTS];

  logic [AW-1:0]     addr_arr [SLOTS];
  logic [SLOTS-1:0]  busy;
  logic [SLOTS-1:0]  pending;
  logic [IW-1:0]     sel_d;
  logic              found_d;
  logic              fill;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign addr_arr[gi]             = slot_addr[gi*AW +: AW];
      assign slot_ok[gi]              = slot_cs[gi] & valid_q[gi] &
                                        (addr_arr[gi] == tag_q[gi]) & ~downloading;
      assign slot_dout[gi*32 +: 32]   = data_q[gi];
      // The slot in flight must not be granted again until its fill lands
      assign busy[gi]                 = (state_q != IDLE) && (gnt_q == IW'(gi));
      assign pending[gi]              = slot_cs[gi] & ~slot_ok[gi] & ~busy[gi];
    end
  endgenerate

  // First pending slot after the last one served, wrapping modulo SLOTS
  always_comb begin
    logic [IW:0] idx;
    found_d = 1'b0;
    sel_d   = '0;
    idx     = '0;
    for (int k = 1; k <= SLOTS; k++) begin
      idx = {1'b0, rr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(SLOTS)) idx = idx - (IW+1)'(SLOTS);
      if (!found_d && pending[idx[IW-1:0]]) begin
        found_d = 1'b1;
        sel_d   = idx[IW-1:0];
      end
    end
  end

  // An ack coinciding with data_rdy is taken as ack followed by rdy
  assign fill = ((state_q == WAIT_ACK) && sdram_ack && data_rdy) ||
                ((state_q == WAIT_RDY) && data_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= IW'(SLOTS-1);
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d && !downloading && !loop_rst) begin
            gnt_q   <= sel_d;
            addr_q  <= addr_arr[sel_d];
            req_q   <= 1'b1;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= data_rdy ? IDLE : WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (data_rdy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (fill) rr_q <= gnt_q;

      // A download overwrites ROM contents, so any fill landing during it is stale
      if (downloading) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[gnt_q] <= 1'b1;
        tag_q[gnt_q]   <= addr_q;
        data_q[gnt_q]  <= data_read;
      end
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule
